// File: rtl/undistort_pkg.sv
// Shared types and defaults for the undistort stream sequencer.
package undistort_pkg;

    localparam int unsigned IMG_W_DEF  = 640;
    localparam int unsigned IMG_H_DEF  = 480;
    localparam int unsigned DEPTH_DEF  = 20;
    localparam int unsigned ADDR_W_DEF = 19;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Output-pixel framing flags carried alongside out_valid.
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } frame_flags_t;

    // Bits needed for a latency counter that counts 0..depth-1.
    function automatic int unsigned lat_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x/y/linear address with clear and advance.
// The flag outputs decode the current registered position.
module raster_counter #(
    parameter int unsigned W      = 4,
    parameter int unsigned H      = 3,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_W-1:0] y,
    output logic [ADDR_W-1:0] addr,
    output logic              sof_c,
    output logic              eol_c,
    output logic              eof_c
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(H - 1);

    assign sof_c = (x == '0) && (y == '0);
    assign eol_c = (x == X_LAST);
    assign eof_c = eol_c && (y == Y_LAST);

    // Position register; wraps to the origin after the last pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (eof_c) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else begin
                addr <= addr + ADDR_W'(1);
                if (eol_c) begin
                    x <= '0;
                    y <= y + ADDR_W'(1);
                end else begin
                    x <= x + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/undistort_stream_ctrl.sv
// Frame sequencer: issues raster-order map reads and emits output framing
// DEPTH cycles behind the reads. All outputs come straight from flops.
module undistort_stream_ctrl
    import undistort_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              abort,
    output logic              map_rd_en,
    output logic [ADDR_W-1:0] map_addr,
    output logic              coeff_fifo_start,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_overrun
);

    localparam int unsigned       N_PIX     = IMG_W * IMG_H;
    localparam int unsigned       LAT_W     = lat_width(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIX - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    frame_flags_t       flags_q, flags_d;

    logic               rd_en_d, fifo_d, valid_d, done_d, busy_d, ovr_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               cnt_clear_c;

    logic [ADDR_W-1:0]  rd_x, rd_y, rd_addr;
    logic               rd_sof_c, rd_eol_c, rd_eof_c;
    logic [ADDR_W-1:0]  px_x, px_y, px_addr;
    logic               px_sof_c, px_eol_c, px_eof_c;
    logic               cnt_unused;

    // Read-side position: next map address to issue.
    raster_counter #(.W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)) u_rd_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear_c),
        .advance (rd_en_d),
        .x       (rd_x),
        .y       (rd_y),
        .addr    (rd_addr),
        .sof_c   (rd_sof_c),
        .eol_c   (rd_eol_c),
        .eof_c   (rd_eof_c)
    );

    // Output-side position: next output pixel to be flagged.
    raster_counter #(.W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)) u_px_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear_c),
        .advance (valid_d),
        .x       (px_x),
        .y       (px_y),
        .addr    (px_addr),
        .sof_c   (px_sof_c),
        .eol_c   (px_eol_c),
        .eof_c   (px_eof_c)
    );

    assign cnt_unused = ^{rd_x, rd_y, rd_sof_c, rd_eol_c, rd_eof_c, px_x, px_y, px_addr};

    // Next state and next registered output values.
    always_comb begin
        state_d     = state_q;
        lat_d       = '0;
        rd_en_d     = 1'b0;
        addr_d      = '0;
        fifo_d      = 1'b0;
        valid_d     = 1'b0;
        flags_d     = '0;
        done_d      = 1'b0;
        busy_d      = 1'b0;
        ovr_d       = 1'b0;
        cnt_clear_c = 1'b0;

        if ((state_q != S_IDLE) && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (frame_start)              state_d = S_FILL;
                S_FILL:  if (lat_q == LAT_LAST)        state_d = S_RUN;
                S_RUN:   if (map_addr == ADDR_LAST)    state_d = S_DRAIN;
                S_DRAIN: if (lat_q == LAT_LAST)        state_d = S_DONE;
                S_DONE:                                state_d = S_IDLE;
                default:                               state_d = S_IDLE;
            endcase
        end

        busy_d      = (state_d != S_IDLE);
        rd_en_d     = (state_d == S_FILL) || (state_d == S_RUN);
        fifo_d      = rd_en_d || (state_d == S_DRAIN);
        valid_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        cnt_clear_c = !busy_d || done_d;

        if (rd_en_d) begin
            addr_d = rd_addr;
        end else if (state_d == S_DRAIN) begin
            addr_d = map_addr;
        end

        if (valid_d) begin
            flags_d.sof = px_sof_c;
            flags_d.eol = px_eol_c;
            flags_d.eof = px_eof_c;
        end

        if ((state_d == state_q) && ((state_q == S_FILL) || (state_q == S_DRAIN))) begin
            lat_d = lat_q + LAT_W'(1);
        end

        ovr_d = frame_start && (state_q != S_IDLE) && !abort;
    end

    // State, latency counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            lat_q            <= '0;
            map_rd_en        <= 1'b0;
            map_addr         <= '0;
            coeff_fifo_start <= 1'b0;
            out_valid        <= 1'b0;
            flags_q          <= '0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            frame_overrun    <= 1'b0;
        end else begin
            state_q          <= state_d;
            lat_q            <= lat_d;
            map_rd_en        <= rd_en_d;
            map_addr         <= addr_d;
            coeff_fifo_start <= fifo_d;
            out_valid        <= valid_d;
            flags_q          <= flags_d;
            busy             <= busy_d;
            frame_done       <= done_d;
            frame_overrun    <= ovr_d;
        end
    end

    assign out_sof = flags_q.sof;
    assign out_eol = flags_q.eol;
    assign out_eof = flags_q.eof;

endmodule

// File: tb/tb_undistort_stream_ctrl.sv
// Randomized bench: two sequencers (4x3 and 1x6, DEPTH=5) against a
// frame-timeline reference model indexed by cycles since frame start.
module tb_undistort_stream_ctrl;

    localparam int unsigned AW = 8;
    localparam int W0 = 4, H0 = 3, D0 = 5;
    localparam int W1 = 1, H1 = 6, D1 = 5;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] fs, ab;

    logic          rd0, coeff0, val0, sof0, eol0, eof0, busy0, done0, ovr0;
    logic [AW-1:0] addr0;
    logic          rd1, coeff1, val1, sof1, eol1, eof1, busy1, done1, ovr1;
    logic [AW-1:0] addr1;

    int total = 0;
    int bad   = 0;
    int t_m[2];
    bit ovr_m[2];
    int frames[2];
    bit rst_hit;

    always #5 clk = ~clk;

    undistort_stream_ctrl #(.IMG_W(W0), .IMG_H(H0), .DEPTH(D0), .ADDR_W(AW)) dut0 (
        .clk(clk), .rst(rst), .frame_start(fs[0]), .abort(ab[0]),
        .map_rd_en(rd0), .map_addr(addr0), .coeff_fifo_start(coeff0),
        .out_valid(val0), .out_sof(sof0), .out_eol(eol0), .out_eof(eof0),
        .busy(busy0), .frame_done(done0), .frame_overrun(ovr0)
    );

    undistort_stream_ctrl #(.IMG_W(W1), .IMG_H(H1), .DEPTH(D1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst(rst), .frame_start(fs[1]), .abort(ab[1]),
        .map_rd_en(rd1), .map_addr(addr1), .coeff_fifo_start(coeff1),
        .out_valid(val1), .out_sof(sof1), .out_eol(eol1), .out_eof(eof1),
        .busy(busy1), .frame_done(done1), .frame_overrun(ovr1)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow from t = cycles since the frame_start edge.
    task automatic check_dut(input int i);
        int w, h, d, n, t, p;
        bit val;
        int unsigned exp_addr;
        logic [AW-1:0] a;
        logic [8:0] o;
        w = (i == 0) ? W0 : W1;
        h = (i == 0) ? H0 : H1;
        d = (i == 0) ? D0 : D1;
        n = w * h;
        t = t_m[i];
        p = t - d - 1;
        val = (t >= d + 1) && (t <= n + d);
        if (t >= 1 && t <= n)          exp_addr = 32'(t - 1);
        else if (t > n && t <= n + d)  exp_addr = 32'(n - 1);
        else                           exp_addr = 0;
        if (i == 0) begin
            a = addr0;
            o = {busy0, rd0, coeff0, val0, sof0, eol0, eof0, done0, ovr0};
        end else begin
            a = addr1;
            o = {busy1, rd1, coeff1, val1, sof1, eol1, eof1, done1, ovr1};
        end
        check($sformatf("d%0d.busy", i),     32'(o[8]), 32'(t != 0));
        check($sformatf("d%0d.map_rd_en", i), 32'(o[7]), 32'(t >= 1 && t <= n));
        check($sformatf("d%0d.map_addr", i),  32'(a),    exp_addr);
        check($sformatf("d%0d.coeff", i),     32'(o[6]), 32'(t >= 1 && t <= n + d));
        check($sformatf("d%0d.valid", i),     32'(o[5]), 32'(val));
        check($sformatf("d%0d.sof", i),       32'(o[4]), 32'(val && p == 0));
        check($sformatf("d%0d.eol", i),       32'(o[3]), 32'(val && (p % w) == w - 1));
        check($sformatf("d%0d.eof", i),       32'(o[2]), 32'(val && p == n - 1));
        check($sformatf("d%0d.done", i),      32'(o[1]), 32'(t == n + d + 1));
        check($sformatf("d%0d.overrun", i),   32'(o[0]), 32'(ovr_m[i]));
    endtask

    // Advance the reference by one clock using the inputs sampled at it.
    task automatic model_step(input int i);
        int n, d;
        bit f, a, act;
        n = (i == 0) ? W0 * H0 : W1 * H1;
        d = (i == 0) ? D0 : D1;
        f = fs[i];
        a = ab[i];
        act = (t_m[i] != 0);
        ovr_m[i] = f && act && !a;
        if (act && a) begin
            t_m[i] = 0;
        end else if (!act) begin
            t_m[i] = f ? 1 : 0;
        end else if (t_m[i] == n + d + 1) begin
            t_m[i] = 0;
        end else begin
            t_m[i]++;
            if (t_m[i] == n + d + 1) frames[i]++;
        end
    endtask

    initial begin
        rst = 1'b0;
        fs = '0;
        ab = '0;
        t_m = '{0, 0};
        ovr_m = '{0, 0};
        frames = '{0, 0};
        rst_hit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        rst = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc == 0) begin
                    fs[i] = 1'b1;
                    ab[i] = 1'b0;
                end else begin
                    fs[i] = (t_m[i] == 0) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 29) == 0);
                    ab[i] = (cyc >= 40) && ($urandom_range(0, 59) == 0);
                end
            end
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            check_dut(0);
            check_dut(1);

            if (!rst_hit && cyc > 200 && t_m[0] == 9) begin
                rst_hit = 1'b1;
                #1 rst = 1'b0;
                #1;
                t_m = '{0, 0};
                ovr_m = '{0, 0};
                check_dut(0);
                check_dut(1);
                #1 rst = 1'b1;
            end
        end

        check("frames_d0", 32'(frames[0] > 0), 1);
        check("frames_d1", 32'(frames[1] > 0), 1);
        check("rst_hit", 32'(rst_hit), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
